// File: rtl/condicionador_botoes_if.sv
// Bundle of signals between the raw push-buttons, the conditioner and the
// memory-game top level. The conditioner drives the master side; whoever
// consumes the clean buttons and supplies the raw levels uses the slave side.
interface condicionador_botoes_if;

    logic [3:0] botoes_brutos;
    logic [3:0] botoes;
    logic [3:0] jogada;
    logic       tem_jogada;
    logic       db_invalida;
    logic [3:0] db_estado;

    modport master (
        input  botoes_brutos,
        output botoes,
        output jogada,
        output tem_jogada,
        output db_invalida,
        output db_estado
    );

    modport slave (
        output botoes_brutos,
        input  botoes,
        input  jogada,
        input  tem_jogada,
        input  db_invalida,
        input  db_estado
    );

endinterface

// File: rtl/condicionador_botoes.sv
// Button conditioner for the memory game: two-flop synchronizer, whole-vector
// debouncer and a small Moore FSM that emits one strobe per single-button
// press, rejects multi-button presses and waits for full release in between.
module condicionador_botoes #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                         clock,
    input  logic                         reset,
    condicionador_botoes_if.master       bus
);

    // Counter wide enough to hold DEBOUNCE_CICLOS-1, never narrower than one bit.
    localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [3:0] {
        OCIOSO        = 4'd0,
        VALIDA        = 4'd1,
        INVALIDA      = 4'd2,
        ESPERA_SOLTAR = 4'd3
    } estado_t;

    logic [3:0]    s1_q, s1_d;
    logic [3:0]    s2_q, s2_d;
    logic [3:0]    candidato_q, candidato_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    estavel_q, estavel_d;
    estado_t       estado_q, estado_d;
    logic [3:0]    jogada_q, jogada_d;
    logic          invalida_q, invalida_d;

    // True when exactly one button of the vector is pressed.
    function automatic logic um_botao(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // Synchronizer stages simply shift the raw levels in.
    always_comb begin
        s1_d = bus.botoes_brutos;
        s2_d = s1_q;
    end

    // Debouncer: any change restarts the count; a value that survives the full
    // window becomes the stable vector, and the counter saturates there.
    always_comb begin
        candidato_d = candidato_q;
        cnt_d       = cnt_q;
        estavel_d   = estavel_q;
        if (s2_q != candidato_q) begin
            candidato_d = s2_q;
            cnt_d       = '0;
        end else if (cnt_q == CNT_MAX) begin
            estavel_d   = candidato_q;
        end else begin
            cnt_d       = cnt_q + 1'b1;
        end
    end

    // Press classification: one strobe per single-button press, an error flag
    // for multi-button presses, and nothing new until every button is released.
    always_comb begin
        estado_d   = estado_q;
        jogada_d   = jogada_q;
        invalida_d = invalida_q;
        case (estado_q)
            OCIOSO: begin
                if (estavel_q != 4'b0000) begin
                    if (um_botao(estavel_q)) begin
                        estado_d = VALIDA;
                        jogada_d = estavel_q;
                    end else begin
                        estado_d   = INVALIDA;
                        invalida_d = 1'b1;
                    end
                end
            end
            VALIDA: begin
                estado_d = ESPERA_SOLTAR;
            end
            INVALIDA: begin
                estado_d = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                if (estavel_q == 4'b0000) begin
                    estado_d   = OCIOSO;
                    invalida_d = 1'b0;
                end
            end
            default: begin
                estado_d   = OCIOSO;
                invalida_d = 1'b0;
            end
        endcase
    end

    // All state registers, cleared together by the synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q        <= 4'b0000;
            s2_q        <= 4'b0000;
            candidato_q <= 4'b0000;
            cnt_q       <= '0;
            estavel_q   <= 4'b0000;
            estado_q    <= OCIOSO;
            jogada_q    <= 4'b0000;
            invalida_q  <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            candidato_q <= candidato_d;
            cnt_q       <= cnt_d;
            estavel_q   <= estavel_d;
            estado_q    <= estado_d;
            jogada_q    <= jogada_d;
            invalida_q  <= invalida_d;
        end
    end

    assign bus.botoes      = estavel_q;
    assign bus.jogada      = jogada_q;
    assign bus.tem_jogada  = (estado_q == VALIDA);
    assign bus.db_invalida = invalida_q;
    assign bus.db_estado   = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for the button conditioner with a short debounce window.
// Expected values are hand-derived edge counts from the moment a raw level
// changes (edge 1 is the first edge that samples it).
module tb_condicionador_botoes;

    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int         vectors       = 0;
    int         miscompares   = 0;
    int         strobe_count  = 0;
    logic [3:0] strobe_jogada = 4'b0000;
    int         base;

    condicionador_botoes_if bus();

    condicionador_botoes #(.DEBOUNCE_CICLOS(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // Counts every strobe and remembers the code that came with it.
    always @(negedge clock) begin
        if (bus.tem_jogada === 1'b1) begin
            strobe_count++;
            strobe_jogada = bus.jogada;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v);
        bus.botoes_brutos = v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] botoes,
                                 input logic [3:0] jogada, input logic tem,
                                 input logic inv, input logic [3:0] estado);
        checkOutput({tag, "_botoes"}, 32'(bus.botoes), 32'(botoes));
        checkOutput({tag, "_jogada"}, 32'(bus.jogada), 32'(jogada));
        checkOutput({tag, "_tem"}, 32'(bus.tem_jogada), 32'(tem));
        checkOutput({tag, "_inv"}, 32'(bus.db_invalida), 32'(inv));
        checkOutput({tag, "_estado"}, 32'(bus.db_estado), 32'(estado));
    endtask

    initial begin
        logic [3:0] codes [4];
        codes[0] = 4'b0001;
        codes[1] = 4'b0010;
        codes[2] = 4'b0100;
        codes[3] = 4'b1000;

        applyStimulus(4'b0000);
        tick(2);
        check_outputs("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        tick(3);

        // Clean press of 0100
        $display("[TB] clean press");
        base = strobe_count;
        applyStimulus(4'b0100);
        tick(6);
        check_outputs("clean_e6", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0);
        tick(1);
        check_outputs("clean_e7", 4'b0100, 4'b0000, 1'b0, 1'b0, 4'd0);
        tick(1);
        check_outputs("clean_e8", 4'b0100, 4'b0100, 1'b1, 1'b0, 4'd1);
        tick(1);
        check_outputs("clean_e9", 4'b0100, 4'b0100, 1'b0, 1'b0, 4'd3);
        tick(11);
        applyStimulus(4'b0000);
        tick(6);
        check_outputs("clean_rel6", 4'b0100, 4'b0100, 1'b0, 1'b0, 4'd3);
        tick(1);
        check_outputs("clean_rel7", 4'b0000, 4'b0100, 1'b0, 1'b0, 4'd3);
        tick(1);
        check_outputs("clean_rel8", 4'b0000, 4'b0100, 1'b0, 1'b0, 4'd0);
        checkOutput("clean_strobes", 32'(strobe_count - base), 32'd1);
        tick(4);

        // Bouncing press of 0010: short pulses must never be accepted
        $display("[TB] bounce");
        base = strobe_count;
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? 4'b0010 : 4'b0000);
            for (int k = 0; k < 2; k++) begin
                tick(1);
                checkOutput($sformatf("bounce_glitch_%0d_%0d", i, k), 32'(bus.botoes), 32'd0);
            end
        end
        applyStimulus(4'b0010);
        tick(6);
        checkOutput("bounce_e6_botoes", 32'(bus.botoes), 32'h0);
        tick(1);
        checkOutput("bounce_e7_tem", 32'(bus.tem_jogada), 32'd0);
        checkOutput("bounce_e7_botoes", 32'(bus.botoes), 32'h2);
        tick(1);
        check_outputs("bounce_e8", 4'b0010, 4'b0010, 1'b1, 1'b0, 4'd1);
        tick(8);
        applyStimulus(4'b0000);
        tick(12);
        checkOutput("bounce_strobes", 32'(strobe_count - base), 32'd1);

        // Two buttons at once: flagged, no strobe, previous code kept
        $display("[TB] invalid press");
        base = strobe_count;
        applyStimulus(4'b0011);
        tick(7);
        check_outputs("inv_e7", 4'b0011, 4'b0010, 1'b0, 1'b0, 4'd0);
        tick(1);
        check_outputs("inv_e8", 4'b0011, 4'b0010, 1'b0, 1'b1, 4'd2);
        tick(1);
        check_outputs("inv_e9", 4'b0011, 4'b0010, 1'b0, 1'b1, 4'd3);
        tick(5);
        applyStimulus(4'b0000);
        tick(7);
        check_outputs("inv_rel7", 4'b0000, 4'b0010, 1'b0, 1'b1, 4'd3);
        tick(1);
        check_outputs("inv_rel8", 4'b0000, 4'b0010, 1'b0, 1'b0, 4'd0);
        checkOutput("inv_strobes", 32'(strobe_count - base), 32'd0);
        tick(4);

        // Hold 1000, add 0001, drop 1000: a single strobe for 1000
        $display("[TB] hold and slide");
        base = strobe_count;
        applyStimulus(4'b1000);
        tick(20);
        applyStimulus(4'b1001);
        tick(15);
        check_outputs("slide_both", 4'b1001, 4'b1000, 1'b0, 1'b0, 4'd3);
        applyStimulus(4'b0001);
        tick(15);
        check_outputs("slide_swap", 4'b0001, 4'b1000, 1'b0, 1'b0, 4'd3);
        applyStimulus(4'b0000);
        tick(15);
        checkOutput("slide_strobes", 32'(strobe_count - base), 32'd1);
        checkOutput("slide_strobe_code", 32'(strobe_jogada), 32'h8);
        checkOutput("slide_estado", 32'(bus.db_estado), 32'd0);

        // Reset while waiting for release, button still held afterwards
        $display("[TB] reset mid-press");
        applyStimulus(4'b0001);
        tick(15);
        checkOutput("rst_pre_estado", 32'(bus.db_estado), 32'd3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_outputs("rst_cycle", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0);
        base = strobe_count;
        tick(7);
        check_outputs("rst_e7", 4'b0001, 4'b0000, 1'b0, 1'b0, 4'd0);
        tick(1);
        check_outputs("rst_e8", 4'b0001, 4'b0001, 1'b1, 1'b0, 4'd1);
        tick(3);
        applyStimulus(4'b0000);
        tick(12);
        checkOutput("rst_strobes", 32'(strobe_count - base), 32'd1);

        // Four single presses in a row, each fully released in between
        $display("[TB] back-to-back");
        base = strobe_count;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(codes[i]);
            tick(7);
            checkOutput($sformatf("b2b_%0d_e7_tem", i), 32'(bus.tem_jogada), 32'd0);
            tick(1);
            checkOutput($sformatf("b2b_%0d_e8_tem", i), 32'(bus.tem_jogada), 32'd1);
            checkOutput($sformatf("b2b_%0d_jogada", i), 32'(bus.jogada), 32'(codes[i]));
            tick(4);
            applyStimulus(4'b0000);
            tick(8);
            checkOutput($sformatf("b2b_%0d_idle", i), 32'(bus.db_estado), 32'd0);
            tick(N + 4);
        end
        checkOutput("b2b_strobes", 32'(strobe_count - base), 32'd4);
        checkOutput("b2b_last_code", 32'(strobe_jogada), 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
